// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
//
// Purpose: groups the instruction-ROM, decode-handshake, redirect and
// (optionally) debug-read signals of the fetch sequencer into one bundle.
//
// Signals:
//   oRomAddress      address presented to the combinational instruction ROM
//   iRomInstruction  ROM data for oRomAddress, same cycle
//   oInstruction     instruction at the head of the fetch buffer
//   oPC              address of the head instruction
//   oValid           head entry valid
//   iReady           decode accepts the head entry
//   iRedirect        jump taken, restart fetching at iTarget
//   iTarget          redirect target address
//   iDbgReq          debug ROM read request, held until oDbgAck
//   iDbgAddress      debug read address
//   oDbgAck          one-cycle debug read acknowledge
//   oDbgData         debug read data, valid with oDbgAck
//
// Configuration macro: FETCH_DEBUG_PORT_EN adds the four debug signals.
//
// Modports:
//   master  the fetch sequencer itself
//   slave   the ROM / decode / debug environment around it

interface fetch_sequencer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int INSN_WIDTH = 28
);
    logic [ADDR_WIDTH-1:0] oRomAddress;
    logic [INSN_WIDTH-1:0] iRomInstruction;
    logic [INSN_WIDTH-1:0] oInstruction;
    logic [ADDR_WIDTH-1:0] oPC;
    logic                  oValid;
    logic                  iReady;
    logic                  iRedirect;
    logic [ADDR_WIDTH-1:0] iTarget;
`ifdef FETCH_DEBUG_PORT_EN
    logic                  iDbgReq;
    logic [ADDR_WIDTH-1:0] iDbgAddress;
    logic                  oDbgAck;
    logic [INSN_WIDTH-1:0] oDbgData;
`endif

    modport master (
        output oRomAddress,
        input  iRomInstruction,
        output oInstruction,
        output oPC,
        output oValid,
        input  iReady,
        input  iRedirect,
        input  iTarget
`ifdef FETCH_DEBUG_PORT_EN
        ,
        input  iDbgReq,
        input  iDbgAddress,
        output oDbgAck,
        output oDbgData
`endif
    );

    modport slave (
        input  oRomAddress,
        output iRomInstruction,
        input  oInstruction,
        input  oPC,
        input  oValid,
        output iReady,
        output iRedirect,
        output iTarget
`ifdef FETCH_DEBUG_PORT_EN
        ,
        output iDbgReq,
        output iDbgAddress,
        input  oDbgAck,
        input  oDbgData
`endif
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//
// Purpose: sequential instruction fetch from a combinational ROM into a
// two-entry {instruction, address} buffer feeding decode. Jumps flush the
// buffer and restart at the target. An optional debug port steals single
// ROM cycles for debugger reads, forced after a bounded wait.
//
// Ports:
//   Clock  rising-edge clock
//   Reset  asynchronous active-low reset
//   bus    fetch_sequencer_if.master (ROM, decode handshake, redirect, debug)
//
// Parameters:
//   ADDR_WIDTH    ROM address width
//   INSN_WIDTH    instruction width
//   RESET_PC      first fetch address after reset
//   DBG_MAX_WAIT  cycles a pending debug read may wait before it is forced
//
// Configuration macro: FETCH_DEBUG_PORT_EN enables the debug read port,
// its wait counter and the S_DBG state. Without it the ROM address is
// always the PC (RESET_PC while initialising).

module fetch_sequencer #(
    parameter int          ADDR_WIDTH   = 16,
    parameter int          INSN_WIDTH   = 28,
    parameter int unsigned RESET_PC     = 0,
    parameter int          DBG_MAX_WAIT = 4
) (
    input logic               Clock,
    input logic               Reset,
    fetch_sequencer_if.master bus
);

    localparam logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(RESET_PC);

`ifdef FETCH_DEBUG_PORT_EN
    typedef enum logic [1:0] {S_INIT, S_FETCH, S_DBG} state_e;
`else
    typedef enum logic {S_INIT, S_FETCH} state_e;
`endif

    state_e                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [1:0]            count;
    logic [INSN_WIDTH-1:0] headInsn;
    logic [INSN_WIDTH-1:0] tailInsn;
    logic [ADDR_WIDTH-1:0] headPc;
    logic [ADDR_WIDTH-1:0] tailPc;
    logic                  full;
    logic                  pop;
    logic                  push;

    assign full = (count == 2'd2);
    assign pop  = (count != 2'd0) && bus.iReady;

    // A slot frees up in the same cycle decode pops, so a full buffer
    // can still fetch when the head is being accepted.
    assign push = (state == S_FETCH) && !bus.iRedirect && (!full || pop);

    assign bus.oValid       = (count != 2'd0);
    assign bus.oInstruction = headInsn;
    assign bus.oPC          = headPc;

`ifdef FETCH_DEBUG_PORT_EN
    localparam int WAIT_BITS = $clog2(DBG_MAX_WAIT + 2);

    logic [WAIT_BITS-1:0]  waitCount;
    logic                  dbgAck;
    logic [INSN_WIDTH-1:0] dbgData;
    logic                  dbgPending;
    logic                  dbgEnter;

    // The requester still holds iDbgReq during its ack cycle; masking it
    // there keeps that cycle from counting as a new request.
    assign dbgPending = bus.iDbgReq && !dbgAck;

    // Steal the ROM when fetch could not use it anyway (buffer stuck full,
    // or a redirect cycle), or when the request has waited long enough.
    assign dbgEnter = (state == S_FETCH) && dbgPending &&
                      ((full && !pop) || bus.iRedirect ||
                       (waitCount >= WAIT_BITS'(DBG_MAX_WAIT)));

    assign bus.oDbgAck  = dbgAck;
    assign bus.oDbgData = dbgData;
`endif

    // ROM address mux: fixed during initialisation, debug address during a
    // stolen debug cycle, otherwise the fetch PC (also while stalled).
    always_comb begin
        bus.oRomAddress = pc;
        if (state == S_INIT) begin
            bus.oRomAddress = RESET_ADDR;
        end
`ifdef FETCH_DEBUG_PORT_EN
        else if (state == S_DBG) begin
            bus.oRomAddress = bus.iDbgAddress;
        end
`endif
    end

    // Control FSM with the registered debug outputs and the wait counter.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= S_INIT;
`ifdef FETCH_DEBUG_PORT_EN
            waitCount <= '0;
            dbgAck    <= 1'b0;
            dbgData   <= '0;
`endif
        end else begin
`ifdef FETCH_DEBUG_PORT_EN
            dbgAck <= 1'b0;
`endif
            case (state)
                S_INIT:  state <= S_FETCH;
`ifdef FETCH_DEBUG_PORT_EN
                S_FETCH: if (dbgEnter) state <= S_DBG;
                S_DBG: begin
                    state   <= S_FETCH;
                    dbgAck  <= 1'b1;
                    dbgData <= bus.iRomInstruction;
                end
`else
                S_FETCH: state <= S_FETCH;
`endif
                default: state <= S_INIT;
            endcase
`ifdef FETCH_DEBUG_PORT_EN
            if ((state == S_DBG) || !dbgPending) begin
                waitCount <= '0;
            end else if (waitCount != '1) begin
                waitCount <= waitCount + 1'b1;
            end
`endif
        end
    end

    // Fetch PC and two-entry buffer. A redirect wins over everything: the
    // buffer is emptied (an entry popped in that cycle is simply dropped)
    // and fetching restarts at the target.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pc       <= RESET_ADDR;
            count    <= 2'd0;
            headInsn <= '0;
            tailInsn <= '0;
            headPc   <= '0;
            tailPc   <= '0;
        end else if (bus.iRedirect) begin
            pc    <= bus.iTarget;
            count <= 2'd0;
        end else begin
            if (push) begin
                pc <= pc + 1'b1;
            end
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        headInsn <= bus.iRomInstruction;
                        headPc   <= pc;
                    end else begin
                        tailInsn <= bus.iRomInstruction;
                        tailPc   <= pc;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    headInsn <= tailInsn;
                    headPc   <= tailPc;
                    count    <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        headInsn <= bus.iRomInstruction;
                        headPc   <= pc;
                    end else begin
                        headInsn <= tailInsn;
                        headPc   <= tailPc;
                        tailInsn <= bus.iRomInstruction;
                        tailPc   <= pc;
                    end
                end
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//
// Purpose: directed scenarios for fetch_sequencer. Each scenario queues the
// addresses decode should receive, in order; a monitor pops and compares
// every accepted head entry. Timing points (first valid, bubbles, held
// head, debug ack) are checked directly by the stimulus process.
//
// The ROM model returns {12'hC3A, address}.

module tb_fetch_sequencer;

    localparam int AW = 16;
    localparam int IW = 28;

    logic Clock = 1'b0;
    logic Reset = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] expQ[$];
    logic [AW-1:0] expPc;

    fetch_sequencer_if #(.ADDR_WIDTH(AW), .INSN_WIDTH(IW)) bus ();

    fetch_sequencer #(
        .ADDR_WIDTH  (AW),
        .INSN_WIDTH  (IW),
        .RESET_PC    (0),
        .DBG_MAX_WAIT(4)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clock = ~Clock;

    function automatic logic [IW-1:0] romWord(input logic [AW-1:0] a);
        return {12'hC3A, a};
    endfunction

    // Combinational ROM answering whatever address the sequencer presents.
    always_comb bus.iRomInstruction = romWord(bus.oRomAddress);

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic redir,
                                 input logic [AW-1:0] tgt);
        bus.iReady    = rdy;
        bus.iRedirect = redir;
        bus.iTarget   = tgt;
    endtask

    // Assert reset away from the clock edge, check the reset values, then
    // release it 2 time units after a rising edge (start of S_INIT cycle).
    task automatic resetDut(input logic rdy);
        @(posedge Clock);
        #2;
        Reset = 1'b0;
        applyStimulus(rdy, 1'b0, '0);
        #1;
        checkOutput("reset oValid", 32'(bus.oValid), 32'd0);
        checkOutput("reset oPC", 32'(bus.oPC), 32'd0);
        checkOutput("reset oInstruction", 32'(bus.oInstruction), 32'd0);
        checkOutput("reset oRomAddress", 32'(bus.oRomAddress), 32'd0);
`ifdef FETCH_DEBUG_PORT_EN
        checkOutput("reset oDbgAck", 32'(bus.oDbgAck), 32'd0);
        checkOutput("reset oDbgData", 32'(bus.oDbgData), 32'd0);
`endif
        expQ.delete();
        @(posedge Clock);
        @(posedge Clock);
        #2;
        Reset = 1'b1;
    endtask

    // Scoreboard monitor: an entry counts as delivered when valid and ready
    // are both high outside a redirect cycle.
    always @(negedge Clock) begin
        if (Reset && bus.oValid && bus.iReady && !bus.iRedirect) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard unexpected: got pc 0x%0h, required no delivery", bus.oPC);
            end else begin
                expPc = expQ.pop_front();
                checkOutput("scoreboard pc", 32'(bus.oPC), 32'(expPc));
                checkOutput("scoreboard insn", 32'(bus.oInstruction), 32'(romWord(expPc)));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b0, 1'b0, '0);
`ifdef FETCH_DEBUG_PORT_EN
        bus.iDbgReq     = 1'b0;
        bus.iDbgAddress = '0;
`endif

        // Scenario A: stream from reset with decode always ready.
        resetDut(1'b1);
        #1;
        checkOutput("A init rom address", 32'(bus.oRomAddress), 32'd0);
        for (int i = 0; i < 6; i++) expQ.push_back(AW'(i));
        @(posedge Clock);
        @(negedge Clock);
        checkOutput("A valid after edge1", 32'(bus.oValid), 32'd0);
        @(posedge Clock);
        @(negedge Clock);
        checkOutput("A first valid", 32'(bus.oValid), 32'd1);
        checkOutput("A first pc", 32'(bus.oPC), 32'd0);
        for (int i = 1; i < 6; i++) begin
            @(negedge Clock);
            checkOutput("A stream valid", 32'(bus.oValid), 32'd1);
        end
        @(posedge Clock);
        #1;
        applyStimulus(1'b0, 1'b0, '0);
        @(negedge Clock);
        checkOutput("A leftover", 32'(expQ.size()), 32'd0);

        // Scenario B: decode stalled, buffer fills, then drains with no gap.
        resetDut(1'b0);
        repeat (4) @(posedge Clock);
        @(negedge Clock);
        checkOutput("B stalled valid", 32'(bus.oValid), 32'd1);
        checkOutput("B stalled pc", 32'(bus.oPC), 32'd0);
        checkOutput("B stalled rom address", 32'(bus.oRomAddress), 32'd2);
        for (int i = 0; i < 4; i++) expQ.push_back(AW'(i));
        @(posedge Clock);
        #1;
        applyStimulus(1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            checkOutput("B nogap valid", 32'(bus.oValid), 32'd1);
            checkOutput("B nogap pc", 32'(bus.oPC), 32'(i));
        end
        @(posedge Clock);
        #1;
        applyStimulus(1'b0, 1'b0, '0);
        @(negedge Clock);
        checkOutput("B leftover", 32'(expQ.size()), 32'd0);

        // Scenario C: redirect to 5 while entry 1 is at the head.
        resetDut(1'b1);
        expQ.push_back(AW'(0));
        expQ.push_back(AW'(5));
        expQ.push_back(AW'(6));
        expQ.push_back(AW'(7));
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        checkOutput("C first pc", 32'(bus.oPC), 32'd0);
        @(posedge Clock);
        #1;
        applyStimulus(1'b0, 1'b1, AW'(5));
        @(negedge Clock);
        checkOutput("C head at redirect", 32'(bus.oPC), 32'd1);
        @(posedge Clock);
        #1;
        applyStimulus(1'b1, 1'b0, '0);
        @(negedge Clock);
        checkOutput("C bubble after redirect", 32'(bus.oValid), 32'd0);
        @(negedge Clock);
        checkOutput("C target valid", 32'(bus.oValid), 32'd1);
        checkOutput("C target pc", 32'(bus.oPC), 32'd5);
        repeat (2) @(negedge Clock);
        @(posedge Clock);
        #1;
        applyStimulus(1'b0, 1'b0, '0);
        @(negedge Clock);
        checkOutput("C leftover", 32'(expQ.size()), 32'd0);

        // Scenario D: PC wraps from 0xFFFF to 0x0000 (redirect in S_INIT).
        resetDut(1'b1);
        #1;
        checkOutput("D init rom address", 32'(bus.oRomAddress), 32'd0);
        applyStimulus(1'b1, 1'b1, 16'hFFFE);
        expQ.push_back(16'hFFFE);
        expQ.push_back(16'hFFFF);
        expQ.push_back(16'h0000);
        expQ.push_back(16'h0001);
        @(posedge Clock);
        #1;
        applyStimulus(1'b1, 1'b0, '0);
        @(posedge Clock);
        @(negedge Clock);
        checkOutput("D first pc", 32'(bus.oPC), 32'hFFFE);
        @(negedge Clock);
        checkOutput("D top pc", 32'(bus.oPC), 32'hFFFF);
        @(negedge Clock);
        checkOutput("D wrap pc", 32'(bus.oPC), 32'h0000);
        @(negedge Clock);
        @(posedge Clock);
        #1;
        applyStimulus(1'b0, 1'b0, '0);
        @(negedge Clock);
        checkOutput("D leftover", 32'(expQ.size()), 32'd0);

`ifdef FETCH_DEBUG_PORT_EN
        // Scenario E: debug read of ROM[3] forced after the wait limit.
        resetDut(1'b1);
        for (int i = 0; i < 10; i++) expQ.push_back(AW'(i));
        repeat (3) @(posedge Clock);
        #1;
        bus.iDbgReq     = 1'b1;
        bus.iDbgAddress = AW'(3);
        repeat (5) @(posedge Clock);
        @(negedge Clock);
        checkOutput("E ack not early", 32'(bus.oDbgAck), 32'd0);
        checkOutput("E debug rom address", 32'(bus.oRomAddress), 32'd3);
        @(posedge Clock);
        #1;
        bus.iDbgReq = 1'b0;
        @(negedge Clock);
        checkOutput("E ack", 32'(bus.oDbgAck), 32'd1);
        checkOutput("E debug data", 32'(bus.oDbgData), 32'(romWord(AW'(3))));
        checkOutput("E fetch bubble", 32'(bus.oValid), 32'd0);
        @(negedge Clock);
        checkOutput("E ack one cycle", 32'(bus.oDbgAck), 32'd0);
        checkOutput("E resume valid", 32'(bus.oValid), 32'd1);
        checkOutput("E resume pc", 32'(bus.oPC), 32'd7);
        repeat (3) @(posedge Clock);
        #1;
        applyStimulus(1'b0, 1'b0, '0);
        @(negedge Clock);
        checkOutput("E leftover", 32'(expQ.size()), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, 16, instruction ROM address width.
REQ-002 Parameter INSN_WIDTH, 28, instruction word width.
REQ-003 Parameter RESET_PC, 0, first fetch address after reset.
REQ-004 Parameter DBG_MAX_WAIT, 4, max cycles a pending debug read waits before forced grant.
REQ-005 The clock and reset ports SHALL be: one clock, Clock; reset, Reset, asynchronous, active-low.
REQ-006 Clock  input  1  single rising-edge clock.
REQ-007 Reset  input  1  asynchronous active-low reset.
REQ-008 oRomAddress  output  ADDR_WIDTH  address to combinational instruction ROM.
REQ-009 iRomInstruction  input  INSN_WIDTH  ROM data, valid in same cycle as oRomAddress.
REQ-010 oInstruction / oPC  output  INSN_WIDTH / ADDR_WIDTH  buffer-head instruction and its address.
REQ-011 oValid  output  1  buffer head valid; iReady  input  1  decode accepts head.
REQ-012 iRedirect  input  1  jump taken; iTarget  input  ADDR_WIDTH  new fetch address.
REQ-013 iDbgReq / iDbgAddress  input  1 / ADDR_WIDTH  debug ROM read request (level, held until ack).
REQ-014 oDbgAck / oDbgData  output  1 / INSN_WIDTH  one-cycle ack pulse, read data valid with ack.

Function
REQ-015 FSM states: S_INIT, S_FETCH, S_DBG; S_INIT lasts exactly one cycle after reset release, then S_FETCH.
REQ-016 Two-entry FIFO holds {instruction, address}; oValid = (count != 0); pop on oValid && iReady.
REQ-017 S_FETCH, no redirect, (count < 2 or pop this cycle): oRomAddress = PC, entry pushed at edge, PC <= PC + 1.
REQ-018 PC increment wraps modulo 2^ADDR_WIDTH (all-ones -> 0), no flag.
REQ-019 Fetch-to-oValid latency: one cycle; steady state with iReady=1 delivers one instruction per cycle.
REQ-020 count == 2 and no pop: no push, PC held, oRomAddress = PC (read ignored).
REQ-021 iRedirect has top priority in any state: FIFO cleared, no push, PC <= iTarget; first target instruction oValid two cycles after redirect cycle.
REQ-022 Pop in redirect cycle counts as accepted by decode; entry discarded regardless.
REQ-023 Debug wait counter increments each cycle iDbgReq is high and not granted; cleared on grant.
REQ-024 S_FETCH -> S_DBG when iDbgReq and (FIFO full without pop, or redirect cycle, or counter == DBG_MAX_WAIT).
REQ-025 S_DBG: one cycle, oRomAddress = iDbgAddress, no push, PC held (unless redirect); oDbgData captured at edge, oDbgAck high next cycle; return to S_FETCH.
REQ-026 Pop remains allowed in S_DBG; oDbgAck never high two consecutive cycles.

Reset
REQ-027 Reset low: PC = RESET_PC, count = 0, state S_INIT, counter 0, oValid = 0, oDbgAck = 0, oInstruction/oDbgData = 0, oPC = 0.
REQ-028 Reset mid-operation discards FIFO contents and any pending debug grant; no ack emitted.
REQ-029 oRomAddress = RESET_PC during reset and S_INIT.

Configuration
REQ-030 Macro FETCH_DEBUG_PORT_EN defined: debug ports, counter and S_DBG present per REQ-013/014/023-026.
REQ-031 Macro undefined: debug ports, counter and S_DBG absent; oRomAddress always PC; fetch behaviour unchanged.

Verification
REQ-032 Reset release, iReady=1, ROM {0:A,1:B,2:C} -> oValid first high 2nd cycle after release; oPC 0,1,2 on consecutive cycles.
REQ-033 iReady=0 for 5 cycles -> count reaches 2, PC stops at 2, oPC held 0; iReady=1 -> oPC 0,1,2 without gap.
REQ-034 iRedirect with iTarget=5 while oPC=1 -> next cycle oValid=0; following cycle oPC=5, entries 1,2 never delivered.
REQ-035 PC=0xFFFF fetched -> next oPC 0x0000 after 0xFFFF.
REQ-036 iDbgReq, iDbgAddress=3, iReady=1 continuous -> grant after exactly 4 waiting cycles, oDbgAck one cycle with ROM[3], one fetch bubble.
REQ-037 Macro undefined build -> scenarios REQ-032..035 pass unchanged.
